// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the sequencer scheduling controller.
// The sequencer is observed through its two-bit state code {Q1,Q2}.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    STEER  = 3'd2,
    RETURN = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  typedef enum logic {
    PATH_SHORT = 1'b0,
    PATH_LONG  = 1'b1
  } path_t;

  localparam logic [1:0] SEQ_AA = 2'b00;
  localparam logic [1:0] SEQ_AB = 2'b01;
  localparam logic [1:0] SEQ_AC = 2'b10;
  localparam logic [1:0] SEQ_AD = 2'b11;

  // Intermediate code the sequencer must pass through on its way back to AA.
  function automatic logic [1:0] mid_code(input path_t p);
    if (p == PATH_LONG) begin
      return SEQ_AD;
    end else begin
      return SEQ_AC;
    end
  endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Requester and sequencer-facing signals of seq_ctrl.
// slave is the controller's view; master is the requester/sequencer side.
interface seq_ctrl_if #(
  parameter int NREQ = 2
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] path;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            err;
  logic [IW-1:0]   err_id;
  logic            busy;
  logic            seq_a;
  logic            seq_q1;
  logic            seq_q2;

  modport master (
    output req, path, seq_q1, seq_q2,
    input  gnt, done, err, err_id, busy, seq_a
  );

  modport slave (
    input  req, path, seq_q1, seq_q2,
    output gnt, done, err, err_id, busy, seq_a
  );

endinterface

// File: rtl/seq_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the requester
// after ptr and wraps; the pointer register lives in the parent.
module rr_arbiter
  import seq_ctrl_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  // First requesting index found walking forward from ptr+1 wins.
  always_comb begin
    logic found;
    logic hit;
    int   cand;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    hit   = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand      = (int'(ptr) + i) % N;
      hit       = en && !found && req[cand];
      found     = found | hit;
      win[cand] = win[cand] | hit;
      idx       = hit ? IW'(cand) : idx;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Shares one sequencer between NREQ requesters: grants round-robin, walks the
// sequencer AA->AB->(AC|AD)->AA and reports done or err per job.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 8
) (
  input logic       clk,
  input logic       n_rst,
  seq_ctrl_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   idx_r;
  logic [IW-1:0]   ptr_r;
  path_t           path_r;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_inc_s;
  logic [NREQ-1:0] arb_win_s;
  logic [IW-1:0]   arb_idx_s;
  logic            arb_en_s;
  logic            arb_valid_s;
  logic [1:0]      code_s;
  logic [NREQ-1:0] one_hot_s;

  assign code_s      = {bus.seq_q1, bus.seq_q2};
  assign arb_en_s    = (state_r == IDLE) && (code_s == SEQ_AA);
  assign arb_valid_s = |arb_win_s;
  assign cnt_inc_s   = (cnt_r == CW'(TIMEOUT)) ? cnt_r : cnt_r + CW'(1);
  assign one_hot_s   = NREQ'(1) << idx_r;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr_r),
    .en  (arb_en_s),
    .win (arb_win_s),
    .idx (arb_idx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the timeout fires on the RETURN cycle whose increment reaches TIMEOUT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          state_nxt_s = KICK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      KICK: state_nxt_s = STEER;
      STEER: begin
        if (code_s == SEQ_AB) begin
          state_nxt_s = RETURN;
        end else begin
          state_nxt_s = ERR;
        end
      end
      RETURN: begin
        if (code_s == SEQ_AA) begin
          state_nxt_s = DONE;
        end else if (code_s != mid_code(path_r)) begin
          state_nxt_s = ERR;
        end else if (cnt_inc_s == CW'(TIMEOUT)) begin
          state_nxt_s = ERR;
        end else begin
          state_nxt_s = RETURN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      ERR:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Job latches, RETURN timeout counter and round-robin pointer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_r  <= '0;
      path_r <= PATH_SHORT;
      cnt_r  <= '0;
      ptr_r  <= IW'(NREQ - 1);
    end else begin
      if ((state_r == IDLE) && arb_valid_s) begin
        idx_r  <= arb_idx_s;
        path_r <= path_t'(bus.path[arb_idx_s]);
      end else begin
        idx_r  <= idx_r;
        path_r <= path_r;
      end
      if ((state_r != RETURN) && (state_nxt_s == RETURN)) begin
        cnt_r <= '0;
      end else if (state_r == RETURN) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
      if ((state_r == DONE) || (state_r == ERR)) begin
        ptr_r <= idx_r;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Moore output decode from registered state and job latches.
  always_comb begin
    bus.seq_a  = 1'b0;
    bus.gnt    = '0;
    bus.done   = '0;
    bus.err    = 1'b0;
    bus.err_id = '0;
    bus.busy   = (state_r != IDLE);
    case (state_r)
      KICK: begin
        bus.seq_a = 1'b1;
        bus.gnt   = one_hot_s;
      end
      STEER: bus.seq_a = path_r;
      DONE:  bus.done  = one_hot_s;
      ERR: begin
        bus.err    = 1'b1;
        bus.err_id = idx_r;
      end
      IDLE:    bus.seq_a = 1'b0;
      RETURN:  bus.seq_a = 1'b0;
      default: bus.seq_a = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a behavioural sequencer model that can be
// told to stick in AD.
module tb_seq_ctrl;
  import seq_ctrl_pkg::*;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;
  logic       stuck = 1'b0;
  logic [1:0] code_r;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  seq_ctrl_if #(.NREQ(2)) bus ();

  seq_ctrl #(.NREQ(2), .TIMEOUT(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Sequencer model.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      code_r <= SEQ_AA;
    end else begin
      case (code_r)
        SEQ_AA:  code_r <= bus.seq_a ? SEQ_AB : SEQ_AA;
        SEQ_AB:  code_r <= bus.seq_a ? SEQ_AD : SEQ_AC;
        SEQ_AC:  code_r <= SEQ_AA;
        SEQ_AD:  code_r <= stuck ? SEQ_AD : SEQ_AA;
        default: code_r <= SEQ_AA;
      endcase
    end
  end

  assign bus.seq_q1 = code_r[1];
  assign bus.seq_q2 = code_r[0];

  // Observation word: {gnt, done, seq_a, busy, err, err_id, code}
  wire [9:0] obs = {bus.gnt, bus.done, bus.seq_a, bus.busy, bus.err, bus.err_id, code_r};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst    = 1'b0;
    bus.req  = 2'b00;
    bus.path = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (obs !== 10'b00_00_0_0_0_0_00) $display("FAIL reset_hold: got %b expected %b", obs, 10'b0);
    else pass_cnt++;
    n_rst = 1'b1;
    tick();
    total_cnt++;
    if (obs !== 10'b00_00_0_0_0_0_00) $display("FAIL reset_idle: got %b expected %b", obs, 10'b0);
    else pass_cnt++;
  endtask

  task automatic test_short_job();
    logic [9:0] exp_t [1:6];
    exp_t = '{10'b01_00_1_1_0_0_00, 10'b00_00_0_1_0_0_01, 10'b00_00_0_1_0_0_10,
              10'b00_00_0_1_0_0_00, 10'b00_01_0_1_0_0_00, 10'b00_00_0_0_0_0_00};
    bus.req  = 2'b01;
    bus.path = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 5) bus.req = 2'b00;
      total_cnt++;
      if (obs !== exp_t[c]) $display("FAIL short_job c%0d: got %b expected %b", c, obs, exp_t[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_job();
    logic [9:0] exp_t [1:6];
    exp_t = '{10'b01_00_1_1_0_0_00, 10'b00_00_0_1_0_0_01, 10'b00_00_0_1_0_0_10,
              10'b00_00_0_1_0_0_00, 10'b00_01_0_1_0_0_00, 10'b00_00_0_0_0_0_00};
    bus.req  = 2'b01;
    bus.path = 2'b01;
    tick();
    total_cnt++;
    if (obs !== 10'b01_00_1_1_0_0_00) $display("FAIL mid_kick: got %b expected %b", obs, 10'b01_00_1_1_0_0_00);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== 10'b00_00_1_1_0_0_01) $display("FAIL mid_steer: got %b expected %b", obs, 10'b00_00_1_1_0_0_01);
    else pass_cnt++;
    n_rst = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 10'b00_00_0_0_0_0_00) $display("FAIL mid_reset: got %b expected %b", obs, 10'b0);
    else pass_cnt++;
    #2;
    n_rst    = 1'b1;
    bus.req  = 2'b11;
    bus.path = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) bus.req = 2'b00;
      total_cnt++;
      if (obs !== exp_t[c]) $display("FAIL mid_restart c%0d: got %b expected %b", c, obs, exp_t[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_long_job();
    logic [9:0] exp_t [1:6];
    exp_t = '{10'b10_00_1_1_0_0_00, 10'b00_00_1_1_0_0_01, 10'b00_00_0_1_0_0_11,
              10'b00_00_0_1_0_0_00, 10'b00_10_0_1_0_0_00, 10'b00_00_0_0_0_0_00};
    bus.req  = 2'b10;
    bus.path = 2'b10;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 5) bus.req = 2'b00;
      total_cnt++;
      if (obs !== exp_t[c]) $display("FAIL long_job c%0d: got %b expected %b", c, obs, exp_t[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gd;
    n_rst = 1'b0;
    #1;
    n_rst    = 1'b1;
    bus.req  = 2'b11;
    bus.path = 2'b00;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 19) bus.req = 2'b00;
      exp_gd = 4'b00_00;
      if (c == 1 || c == 13) exp_gd = 4'b01_00;
      if (c == 7 || c == 19) exp_gd = 4'b10_00;
      if (c == 5 || c == 17) exp_gd = 4'b00_01;
      if (c == 11 || c == 23) exp_gd = 4'b00_10;
      total_cnt++;
      if ({bus.gnt, bus.done} !== exp_gd)
        $display("FAIL b2b c%0d: got gnt/done %b expected %b", c, {bus.gnt, bus.done}, exp_gd);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_idle: got busy %b expected 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [9:0] exp_t [1:19];
    exp_t[1]  = 10'b01_00_1_1_0_0_00;
    exp_t[2]  = 10'b00_00_1_1_0_0_01;
    for (int c = 3; c <= 10; c++) exp_t[c] = 10'b00_00_0_1_0_0_11;
    exp_t[11] = 10'b00_00_0_1_1_0_11;
    exp_t[12] = 10'b00_00_0_0_0_0_11;
    exp_t[13] = 10'b00_00_0_0_0_0_00;
    exp_t[14] = 10'b10_00_1_1_0_0_00;
    exp_t[15] = 10'b00_00_0_1_0_0_01;
    exp_t[16] = 10'b00_00_0_1_0_0_10;
    exp_t[17] = 10'b00_00_0_1_0_0_00;
    exp_t[18] = 10'b00_10_0_1_0_0_00;
    exp_t[19] = 10'b00_00_0_0_0_0_00;
    stuck    = 1'b1;
    bus.req  = 2'b01;
    bus.path = 2'b01;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 11) begin
        bus.req  = 2'b11;
        bus.path = 2'b00;
      end
      if (c == 12) stuck = 1'b0;
      if (c == 14) bus.req = 2'b00;
      total_cnt++;
      if (obs !== exp_t[c]) $display("FAIL timeout c%0d: got %b expected %b", c, obs, exp_t[c]);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.path = 2'b00;
    test_reset();
    test_short_job();
    test_reset_mid_job();
    test_long_job();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Scheduling controller that shares one `sequencer` instance between `NREQ` requesters. It arbitrates round-robin and drives the sequencer's `A` input through a complete excursion AA→AB→(AC|AD)→AA. It checks every step against the sequencer's state outputs and reports completion or error per job. The block sits between the requester logic and the `sequencer` instance; the two share `clk` and `n_rst`.

## Interface
- `NREQ`, default 2: number of requesters (≥2).
- `TIMEOUT`, default 8: maximum cycles in RETURN before an error is raised (≥2).
- `clk`, in, 1: clock, rising edge.
- `n_rst`, in, 1: one clock; reset is asynchronous and active-low.
- `req`, in, NREQ: level request per requester; held until its `done` or `err`.
- `path`, in, NREQ: per-requester route. 0 = short via AC, 1 = long via AD. Sampled at grant.
- `gnt`, out, NREQ: one-hot, one-cycle pulse when a job starts.
- `done`, out, NREQ: one-hot, one-cycle pulse on successful return to AA.
- `err`, out, 1: one-cycle pulse on a sequencing fault. Error owner is given by `err_id`.
- `err_id`, out, $clog2(NREQ): index of the faulted job; valid with `err`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `seq_a`, out, 1: drives sequencer `A`.
- `seq_q1`, `seq_q2`, in, 1 each: sequencer `Q1`/`Q2`.

## Operation
- Sequencer state code {Q1,Q2}: AA=00, AB=01, AC=10, AD=11.
- Sequencer transitions: AA: A=1→AB, A=0→AA. AB: A=1→AD, A=0→AC. AC→AA. AD→AA.
- Controller FSM states: IDLE, KICK, STEER, RETURN, DONE, ERR.
- IDLE: if any `req` and code==AA, select the winner, latch index and `path`, then go to KICK. Otherwise stay in IDLE.
- KICK: `seq_a`=1 and `gnt[idx]`=1. After one cycle, go to STEER.
- STEER: code must equal AB.
  - If so, `seq_a`=latched path and go to RETURN next cycle.
  - Otherwise go to ERR.
- RETURN: `seq_a`=0 and the timeout counter increments each cycle.
  - Code==AA → DONE.
  - Code equals the expected intermediate (AC if path=0, AD if path=1) → stay.
  - Any other code → ERR.
  - Counter reaching TIMEOUT → ERR.
- DONE: `done[idx]`=1 and the round-robin pointer advances to idx. Go to IDLE.
- ERR: `err`=1 and `err_id`=idx. The pointer also advances. Go to IDLE.
- Arbitration: round-robin. Priority starts at the requester after the last served one.
- Dropping `req` after grant does not abort the job. `path` changes after grant are ignored.
- `seq_a`, `gnt`, `done`, `err` and `busy` are Moore outputs decoded from registered state and latches only.

## Timing
- Reset (async assert, any state including mid-job):
  - State → IDLE. Counter = 0. Pointer resets so requester 0 has priority.
  - Outputs: `seq_a`=0, `gnt`=0, `done`=0, `err`=0, `err_id`=0, `busy`=0.
- Nominal job, cycles counted from the IDLE cycle with a valid request (cycle 0):
  - Cycle 1: KICK, `gnt` high.
  - Cycle 2: STEER, code AB.
  - Cycle 3: RETURN, code AC/AD.
  - Cycle 4: RETURN sees AA.
  - Cycle 5: `done` high.
  - Cycle 6: back in IDLE.
- Back-to-back jobs: at least one IDLE cycle between jobs, so the next `gnt` comes 6 cycles after the previous `gnt`.
- Request arriving while code≠AA: held off, with no `gnt`, until code==AA.
- Simultaneous requests: exactly one `gnt` per job. The other requester is served next in round-robin order.
- Timeout counter width: $clog2(TIMEOUT+1). It clears on entry to RETURN and saturates at TIMEOUT.

## Structure
- Package `seq_ctrl_pkg`:
  - state enum: IDLE, KICK, STEER, RETURN, DONE, ERR.
  - sequencer code constants: SEQ_AA/AB/AC/AD.
  - path enum: PATH_SHORT, PATH_LONG.
- Sub-module `rr_arbiter` (parameter N):
  - inputs: `req`, pointer, enable.
  - outputs: one-hot `win` and encoded index.
  - purely combinational; the pointer register lives in `seq_ctrl`.
- The FSM, latches and timeout counter live in `seq_ctrl`.

## Test plan
- Reset, then `req`=01, `path[0]`=0 → `gnt`=01 at cycle 1; code sequence AA,AB,AC,AA; `done`=01 at cycle 5; `seq_a`=1,0,0.
- `req[1]`=1, `path[1]`=1 → code AA,AB,AD,AA; `seq_a`=1,1,0; `done`=10 at cycle 5.
- `req`=11 held continuously after reset → grants alternate 01,10,01,10; each `gnt` comes 6 cycles after the previous one.
- Sequencer model forced to stay in AD → `err`=1 with `err_id`=job index after TIMEOUT=8 RETURN cycles; no `done`; next request still served.
- `n_rst` asserted during STEER → all outputs 0 immediately; after release, `req`=01 restarts from KICK with requester 0 winning.
